// File: rtl/buzzer_if.sv
// buzzer_if: register bus between the CPU write/read decoders and the buzzer slave
//   wr/waddr/wdata : one-cycle full-word write strobe, byte address, data
//   rd/raddr/rdata : read strobe, byte address, registered read data
interface buzzer_if #(parameter int ADDRESS_WIDTH = 8);
  logic                     wr;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [31:0]              wdata;
  logic                     rd;
  logic [ADDRESS_WIDTH-1:0] raddr;
  logic [31:0]              rdata;
  modport master (output wr, waddr, wdata, rd, raddr, input rdata);
  modport slave (input wr, waddr, wdata, rd, raddr, output rdata);
endinterface

// File: rtl/buzzer.sv
// buzzer: memory-mapped square-wave tone generator with optional note FIFO
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   bus        : buzzer_if.slave register window (CTRL 0x00, DIV 0x04, DUR 0x08, STATUS 0x0C, NOTE 0x10)
//   buzzer_pin : tone output, 0 when silent
//   BUZZER_NOTE_FIFO_EN : define to build the NOTE register and FIFO_DEPTH-entry note queue
module buzzer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int TICK_DIV = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    rstn,
  buzzer_if.slave bus,
  output logic    buzzer_pin
);
  localparam int PW = $clog2(TICK_DIV + 1);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wa, ra;
  logic [2:0] wsel, rsel;
  logic ctrl_wr, div_wr, dur_wr, kill, start, note_end, loop_reg, load_reg, load_fifo, busy;
  logic en_q, loop_q, src_q, fifo_empty;
  logic [19:0] div_q, cur_div_q, phase_q, ld_div;
  logic [15:0] dur_q, rem_q, ld_dur;
  logic [PW-1:0] presc_q;
  logic [31:0] head, status;
  logic unused_bits;
  assign wa = bus.waddr;
  assign ra = bus.raddr;
  assign unused_bits = ^{wa, ra, bus.wdata};
  assign wsel = wa[4:2];
  assign rsel = ra[4:2];
  assign ctrl_wr = bus.wr & (wsel == 3'd0);
  assign div_wr = bus.wr & (wsel == 3'd1);
  assign dur_wr = bus.wr & (wsel == 3'd2);
  // A CTRL write with EN=0 overrides any START in the same word
  assign kill = ctrl_wr & ~bus.wdata[0];
  assign start = ctrl_wr & bus.wdata[0] & bus.wdata[1] & (dur_q != '0);
  // Last cycle of the last tick of the current note
  assign note_end = (state_q == PLAY) & (presc_q == PW'(1)) & (rem_q[15:1] == '0);
  // LOOP only repeats notes that came from the registers, never FIFO notes
  assign loop_reg = loop_q & ~src_q;
  assign ld_div = load_fifo ? head[19:0] : div_q;
  assign ld_dur = load_fifo ? {4'd0, head[31:20]} : dur_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    load_reg = ~kill & (start | note_end & loop_reg);
    load_fifo = ~kill & ~start & ~fifo_empty & (state_q == IDLE ? en_q : note_end & ~loop_reg);
    state_d = kill ? IDLE : (load_reg | load_fifo) ? PLAY : note_end ? IDLE : state_q;
  end
  always_comb busy = state_q == PLAY;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      en_q <= 1'b0;
      loop_q <= 1'b0;
      div_q <= '0;
      dur_q <= '0;
      cur_div_q <= '0;
      phase_q <= '0;
      rem_q <= '0;
      presc_q <= '0;
      src_q <= 1'b0;
      buzzer_pin <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q <= bus.wdata[0];
        loop_q <= bus.wdata[2];
      end
      if (div_wr) div_q <= bus.wdata[19:0];
      if (dur_wr) dur_q <= bus.wdata[15:0];
      if (load_reg | load_fifo) begin
        cur_div_q <= ld_div;
        phase_q <= ld_div;
        rem_q <= ld_dur;
        presc_q <= PW'(TICK_DIV);
        src_q <= load_fifo;
        buzzer_pin <= 1'b0;
      end else if (state_d == IDLE) buzzer_pin <= 1'b0;
      else begin
        presc_q <= presc_q == PW'(1) ? PW'(TICK_DIV) : presc_q - PW'(1);
        if (presc_q == PW'(1)) rem_q <= rem_q - 16'd1;
        // DIV=0 is a rest: duration runs while the pin stays low
        if (cur_div_q == '0) buzzer_pin <= 1'b0;
        else if (phase_q == 20'd1) begin
          buzzer_pin <= ~buzzer_pin;
          phase_q <= cur_div_q;
        end else phase_q <= phase_q - 20'd1;
      end
    end
`ifdef BUZZER_NOTE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic note_wr, stat_wr, push, fifo_full, ovf_q;
  assign note_wr = bus.wr & (wsel == 3'd4);
  assign stat_wr = bus.wr & (wsel == 3'd3);
  assign fifo_empty = cnt_q == '0;
  assign fifo_full = cnt_q == CW'(FIFO_DEPTH);
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands
  assign push = note_wr & (~fifo_full | load_fifo);
  assign head = mem[rp_q];
  assign status = {28'd0, ovf_q, fifo_full, fifo_empty, busy};
  always_ff @(posedge clk)
    if (push) mem[wp_q] <= bus.wdata;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (kill) begin
        wp_q <= '0;
        rp_q <= '0;
        cnt_q <= '0;
      end else begin
        wp_q <= wp_q + AW'(push);
        rp_q <= rp_q + AW'(load_fifo);
        cnt_q <= cnt_q + CW'(push) - CW'(load_fifo);
      end
      if (note_wr & ~push) ovf_q <= 1'b1;
      else if (stat_wr & bus.wdata[3]) ovf_q <= 1'b0;
    end
`else
  assign fifo_empty = 1'b1;
  assign head = '0;
  assign status = {31'd0, busy};
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) bus.rdata <= '0;
    else if (bus.rd)
      bus.rdata <= rsel == 3'd0 ? {29'd0, loop_q, 1'b0, en_q} :
                   rsel == 3'd1 ? {12'd0, div_q} :
                   rsel == 3'd2 ? {16'd0, dur_q} :
                   rsel == 3'd3 ? status : '0;
endmodule
